// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: memory-op encodings, FSM states and
// the per-op access-length / load-extension decode.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    EXT_ZERO = 1'b0,
    EXT_SIGN = 1'b1
  } ext_e;

  // Index of the final byte of the access (access length minus one).
  function automatic logic [1:0] op_last(input mem_op_e op);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return 2'd1;
      MEM_LW, MEM_SW:          return 2'd3;
      default:                 return 2'd0;
    endcase
  endfunction

  function automatic logic op_is_store(input mem_op_e op);
    case (op)
      MEM_SB, MEM_SH, MEM_SW: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic ext_e op_ext(input mem_op_e op);
    case (op)
      MEM_LB, MEM_LH: return EXT_SIGN;
      default:        return EXT_ZERO;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide memory bus between the MEM stage (master) and memory (slave).
interface mem_stage_if;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_ack;

  modport master (
    output mem_req, mem_wr, mem_a, mem_dout,
    input  mem_din, mem_ack
  );

  modport slave (
    input  mem_req, mem_wr, mem_a, mem_dout,
    output mem_din, mem_ack
  );
endinterface

// File: rtl/lsu_extend.sv
// Load result formatting: picks the loaded width from the op and sign- or
// zero-extends the assembled little-endian buffer to 32 bits.
module lsu_extend
  import mem_stage_pkg::*;
(
  input  logic [31:0] buffer,
  input  mem_op_e     mem_op,
  output logic [31:0] result
);

  logic sign;

  always_comb begin
    result = buffer;
    sign   = (op_ext(mem_op) == EXT_SIGN);
    // Upper buffer bytes may hold stale data from an earlier, wider load.
    unique case (op_last(mem_op))
      2'd0:    result = {{24{sign & buffer[7]}},  buffer[7:0]};
      2'd1:    result = {{16{sign & buffer[15]}}, buffer[15:0]};
      default: result = buffer;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results through to WB, or runs a byte-serial
// load/store over the memory bus while stalling upstream.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        we_in,
  input  logic [4:0]  waddr_in,
  input  logic [31:0] wdata_in,
  input  mem_op_e     mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        stall_req,
  mem_stage_if.master bus,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o
);

  state_e      state;
  state_e      state_next;
  logic [1:0]  cnt;
  logic [31:0] buffer;
  logic [31:0] load_result;
  logic        ack_fire;

  lsu_extend u_extend (
    .buffer (buffer),
    .mem_op (mem_op),
    .result (load_result)
  );

  always_ff @(posedge clk) begin
    if (rst)      state <= ST_IDLE;
    else if (rdy) state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next   = state;
    stall_req    = 1'b0;
    ack_fire     = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.mem_a    = '0;
    bus.mem_dout = '0;
    unique case (state)
      ST_IDLE: begin
        if (mem_op != MEM_NONE) begin
          stall_req  = 1'b1;
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall_req    = 1'b1;
        bus.mem_req  = rdy;
        bus.mem_wr   = rdy & op_is_store(mem_op);
        bus.mem_a    = mem_addr + {30'd0, cnt};
        bus.mem_dout = byte_of(mem_sdata, cnt);
        ack_fire     = rdy & bus.mem_ack;
        if (ack_fire && cnt == op_last(mem_op)) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      buffer  <= '0;
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else if (rdy) begin
      unique case (state)
        ST_IDLE: begin
          if (mem_op == MEM_NONE) begin
            we_o    <= we_in;
            waddr_o <= waddr_in;
            wdata_o <= wdata_in;
          end else begin
            we_o <= 1'b0;
            cnt  <= '0;
          end
        end
        ST_ACCESS: begin
          if (ack_fire) begin
            if (!op_is_store(mem_op)) buffer[{cnt, 3'b000} +: 8] <= bus.mem_din;
            cnt <= cnt + 2'd1;
          end
        end
        ST_DONE: begin
          cnt <= '0;
          if (op_is_store(mem_op)) begin
            we_o <= 1'b0;
          end else begin
            we_o    <= we_in;
            waddr_o <= waddr_in;
            wdata_o <= load_result;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table-driven passthrough and load/store
// vectors against a small byte memory, plus wait-state, freeze and reset sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        we_in;
  logic [4:0]  waddr_in;
  logic [31:0] wdata_in;
  mem_op_e     mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        stall_req;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;

  mem_stage_if bus ();

  mem_stage dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .we_in     (we_in),
    .waddr_in  (waddr_in),
    .wdata_in  (wdata_in),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .mem_sdata (mem_sdata),
    .stall_req (stall_req),
    .bus       (bus),
    .we_o      (we_o),
    .waddr_o   (waddr_o),
    .wdata_o   (wdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
  } xact_t;

  typedef struct {
    mem_op_e     op;
    logic [31:0] addr;
    logic [31:0] mem_word;
    logic [31:0] sdata;
    logic        store;
    logic        we;
    logic [4:0]  waddr;
    int          n;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } op_vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ack_force;
  } pt_vec_t;

  logic [7:0] mem_bytes [logic [31:0]];
  xact_t      xlog [$];
  int         ack_delay = 0;
  logic       ack_force = 1'b0;
  int         wait_cnt  = 0;
  int         n_cmp     = 0;
  int         n_err     = 0;

  // Byte memory: acks after ack_delay waiting cycles, or at once when forced.
  always @* begin
    bus.mem_ack = ack_force | (bus.mem_req & (wait_cnt >= ack_delay));
    bus.mem_din = 8'h00;
    if (bus.mem_req && !bus.mem_wr && mem_bytes.exists(bus.mem_a))
      bus.mem_din = mem_bytes[bus.mem_a];
  end

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ack) begin
      xlog.push_back('{bus.mem_a, bus.mem_wr, bus.mem_dout});
      wait_cnt <= 0;
    end else if (bus.mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] word);
    for (int i = 0; i < 4; i++) mem_bytes[addr + 32'(i)] = word[8*i +: 8];
  endtask

  task automatic idle_inputs();
    mem_op   = MEM_NONE;
    we_in    = 1'b0;
    waddr_in = '0;
    wdata_in = '0;
  endtask

  task automatic check_log(input string name, input logic [31:0] addr, input logic [31:0] word,
                           input logic store, input int n);
    check({name, "_nbytes"}, 32'(xlog.size()), 32'(n));
    for (int i = 0; i < n && i < xlog.size(); i++) begin
      check({name, "_addr"}, xlog[i].a, addr + 32'(i));
      check({name, "_wr"}, {31'd0, xlog[i].wr}, {31'd0, store});
      if (store) check({name, "_wbyte"}, {24'd0, xlog[i].d}, {24'd0, word[8*i +: 8]});
    end
  endtask

  // Applies one memory op with the current ack timing and checks stall length,
  // latency, bus traffic and the write-back result.
  task automatic run_op(input string name, input op_vec_t v);
    int stall_cycles = 0;
    int edges = 0;
    xlog.delete();
    if (!v.store) preload(v.addr, v.mem_word);
    mem_op    = v.op;
    mem_addr  = v.addr;
    mem_sdata = v.sdata;
    we_in     = v.we;
    waddr_in  = v.waddr;
    wdata_in  = 32'h5A5A_5A5A;
    #1;
    while (stall_req && edges < 100) begin
      stall_cycles++;
      tick();
      edges++;
    end
    check({name, "_stall_cycles"}, 32'(stall_cycles), 32'(v.n + 1));
    tick();
    edges++;
    idle_inputs();
    check({name, "_latency"}, 32'(edges), 32'(v.n + 2));
    check({name, "_we_o"}, {31'd0, we_o}, {31'd0, v.exp_we});
    if (!v.store) begin
      check({name, "_waddr_o"}, {27'd0, waddr_o}, {27'd0, v.waddr});
      check({name, "_wdata_o"}, wdata_o, v.exp_wdata);
    end
    check_log(name, v.addr, v.sdata, v.store, v.n);
  endtask

  op_vec_t ops [10];
  pt_vec_t pts [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ops[0] = '{MEM_LW,  32'h0000_0100, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 5'd3,  4, 1'b1, 32'h1234_5678};
    ops[1] = '{MEM_LB,  32'h0000_0200, 32'h0000_0080, 32'h0, 1'b0, 1'b1, 5'd4,  1, 1'b1, 32'hFFFF_FF80};
    ops[2] = '{MEM_LBU, 32'h0000_0200, 32'h0000_0080, 32'h0, 1'b0, 1'b1, 5'd5,  1, 1'b1, 32'h0000_0080};
    ops[3] = '{MEM_LH,  32'h0000_0300, 32'h0000_FF80, 32'h0, 1'b0, 1'b1, 5'd6,  2, 1'b1, 32'hFFFF_FF80};
    ops[4] = '{MEM_LHU, 32'h0000_0301, 32'h0000_BEEF, 32'h0, 1'b0, 1'b1, 5'd7,  2, 1'b1, 32'h0000_BEEF};
    ops[5] = '{MEM_LB,  32'h0000_0400, 32'h0000_007F, 32'h0, 1'b0, 1'b0, 5'd8,  1, 1'b0, 32'h0000_007F};
    ops[6] = '{MEM_LW,  32'h0000_0203, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, 5'd9,  4, 1'b1, 32'hCAFE_F00D};
    ops[7] = '{MEM_SH,  32'hFFFF_FFFF, 32'h0, 32'hAABB_CCDD, 1'b1, 1'b1, 5'd10, 2, 1'b0, 32'h0};
    ops[8] = '{MEM_SW,  32'h0000_0500, 32'h0, 32'h1122_3344, 1'b1, 1'b1, 5'd11, 4, 1'b0, 32'h0};
    ops[9] = '{MEM_SB,  32'h0000_0600, 32'h0, 32'h0000_00A5, 1'b1, 1'b1, 5'd12, 1, 1'b0, 32'h0};

    pts[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b0};
    pts[1] = '{1'b0, 5'd31, 32'hFFFF_FFFF, 1'b0};
    pts[2] = '{1'b1, 5'd17, 32'h8000_0001, 1'b1};
    pts[3] = '{1'b1, 5'd0,  32'h0F0F_0F0F, 1'b0};

    rst       = 1'b1;
    rdy       = 1'b1;
    mem_addr  = '0;
    mem_sdata = '0;
    idle_inputs();
    tick();
    tick();
    check("reset_we_o", {31'd0, we_o}, 32'd0);
    check("reset_waddr_o", {27'd0, waddr_o}, 32'd0);
    check("reset_wdata_o", wdata_o, 32'd0);
    check("reset_stall_req", {31'd0, stall_req}, 32'd0);
    check("reset_mem_req", {31'd0, bus.mem_req}, 32'd0);
    rst = 1'b0;

    foreach (pts[i]) begin
      we_in     = pts[i].we;
      waddr_in  = pts[i].waddr;
      wdata_in  = pts[i].wdata;
      ack_force = pts[i].ack_force;
      #1;
      check("pass_stall_req", {31'd0, stall_req}, 32'd0);
      check("pass_mem_req", {31'd0, bus.mem_req}, 32'd0);
      tick();
      check("pass_we_o", {31'd0, we_o}, {31'd0, pts[i].we});
      check("pass_waddr_o", {27'd0, waddr_o}, {27'd0, pts[i].waddr});
      check("pass_wdata_o", wdata_o, pts[i].wdata);
    end
    ack_force = 1'b0;
    idle_inputs();
    tick();

    foreach (ops[i]) run_op($sformatf("op%0d", i), ops[i]);

    // Wait states plus a two-cycle freeze in the middle of a word load.
    begin
      int edges = 0;
      op_vec_t v = '{MEM_LW, 32'h0000_0700, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 5'd9, 4, 1'b1, 32'hDEAD_BEEF};
      xlog.delete();
      preload(v.addr, v.mem_word);
      ack_delay = 3;
      mem_op    = v.op;
      mem_addr  = v.addr;
      we_in     = v.we;
      waddr_in  = v.waddr;
      while (edges < 200) begin
        if (edges == 7) begin
          rdy       = 1'b0;
          ack_force = 1'b1;
        end
        if (edges == 9) begin
          rdy       = 1'b1;
          ack_force = 1'b0;
        end
        #1;
        if (!rdy) begin
          check("freeze_mem_req", {31'd0, bus.mem_req}, 32'd0);
          check("freeze_stall_req", {31'd0, stall_req}, 32'd1);
        end
        if (!stall_req) break;
        tick();
        edges++;
      end
      check("wait_finished", {31'd0, stall_req}, 32'd0);
      tick();
      idle_inputs();
      check("wait_we_o", {31'd0, we_o}, 32'd1);
      check("wait_wdata_o", wdata_o, v.exp_wdata);
      check_log("wait", v.addr, v.sdata, 1'b0, 4);
      ack_delay = 0;
    end

    // Reset two bytes into a word load, with rdy low to show reset wins.
    xlog.delete();
    mem_op   = MEM_LW;
    mem_addr = 32'h0000_0100;
    we_in    = 1'b1;
    waddr_in = 5'd21;
    tick();
    tick();
    tick();
    check("abort_pre_mem_req", {31'd0, bus.mem_req}, 32'd1);
    check("abort_pre_mem_a", bus.mem_a, 32'h0000_0102);
    rst = 1'b1;
    rdy = 1'b0;
    tick();
    rst = 1'b0;
    rdy = 1'b1;
    idle_inputs();
    #1;
    check("abort_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("abort_stall_req", {31'd0, stall_req}, 32'd0);
    check("abort_we_o", {31'd0, we_o}, 32'd0);
    check("abort_waddr_o", {27'd0, waddr_o}, 32'd0);
    check("abort_wdata_o", wdata_o, 32'd0);
    tick();
    check("abort_no_wb", {31'd0, we_o}, 32'd0);
    run_op("after_abort", ops[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
